pwm_audio_dac: RTL and testbench

//  Audio PWM DAC for the board's mono audio output. Accepts unsigned PCM samples over a

---
 rtl/pwm_audio_dac.sv | 113 +++++++++++
 tb/tb_pwm_audio_dac.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_audio_dac.sv
// rtl/pwm_audio_dac.sv - PCM sample FIFO feeding a fixed-period PWM audio DAC
// One sample per 2**WIDTH-cycle frame; the sample FIFO pops only at frame boundaries.
module pwm_audio_dac #(
  parameter int WIDTH      = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               en,
  input  logic [WIDTH-1:0]                   sample_data,
  input  logic                               sample_valid,
  output logic                               sample_ready,
  output logic                               pwm_out,
  output logic                               underrun,
  input  logic                               underrun_clr,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [CW-1:0]    DEPTH_C = CW'(FIFO_DEPTH);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic             pwm_q, pwm_d;
  logic             underrun_q, underrun_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d [FIFO_DEPTH];

  logic boundary;
  logic fifo_empty;
  logic push;
  logic pop;

  always_comb begin
    boundary   = en && (cnt_q == CNT_MAX);
    fifo_empty = (count_q == '0);
    push       = sample_valid && sample_ready;
    // Pop decision uses the pre-push count, so a same-cycle push is never bypassed.
    pop        = boundary && !fifo_empty;
  end

  always_comb begin
    cnt_d = en ? cnt_q + WIDTH'(1) : '0;
    pwm_d = en && (cnt_q < duty_q);
  end

  always_comb begin
    duty_d     = duty_q;
    underrun_d = underrun_q;
    if (pop) begin
      duty_d = mem_q[rd_ptr_q];
    end
    if (boundary && fifo_empty) begin
      underrun_d = 1'b1;
    end else if (underrun_clr) begin
      underrun_d = 1'b0;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = sample_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      duty_q     <= '0;
      pwm_q      <= 1'b0;
      underrun_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q      <= cnt_d;
      duty_q     <= duty_d;
      pwm_q      <= pwm_d;
      underrun_q <= underrun_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

  assign sample_ready = (count_q < DEPTH_C);
  assign pwm_out      = pwm_q;
  assign underrun     = underrun_q;
  assign fifo_count   = count_q;

endmodule

// File: tb/tb_pwm_audio_dac.sv
// tb/tb_pwm_audio_dac.sv - directed table-driven bench for pwm_audio_dac
// WIDTH=4 gives a 16-cycle frame; each frame's pwm pattern is captured bit-per-cycle.
module tb_pwm_audio_dac;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [WIDTH-1:0] sample_data;
  logic             sample_valid;
  logic             sample_ready;
  logic             pwm_out;
  logic             underrun;
  logic             underrun_clr;
  logic [CW-1:0]    fifo_count;

  pwm_audio_dac #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .pwm_out      (pwm_out),
    .underrun     (underrun),
    .underrun_clr (underrun_clr),
    .fifo_count   (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] duty;
    logic             exp_underrun;
  } vec_t;

  vec_t        tbl [5];
  int          errors = 0;
  int          checks = 0;
  int          edge_idx = 0;
  logic [15:0] pat = '0;
  logic        saw_high;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Records pwm_out after frame edge k into bit k%16 of pat.
  task automatic tick_rec();
    @(posedge clk);
    #1;
    pat[edge_idx % 16] = pwm_out;
    edge_idx++;
  endtask

  function automatic logic [15:0] mask(input int d);
    logic [15:0] m;
    for (int i = 0; i < 16; i++) m[i] = (i < d);
    return m;
  endfunction

  initial begin
    tbl[0] = '{duty: 4'd5,  exp_underrun: 1'b0};
    tbl[1] = '{duty: 4'd0,  exp_underrun: 1'b0};
    tbl[2] = '{duty: 4'd15, exp_underrun: 1'b0};
    tbl[3] = '{duty: 4'd1,  exp_underrun: 1'b0};
    tbl[4] = '{duty: 4'd8,  exp_underrun: 1'b1};

    rst_n = 1'b0; en = 1'b0; sample_data = '0; sample_valid = 1'b0; underrun_clr = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("reset_pwm", 32'(pwm_out), 0);
    chk("reset_count", 32'(fifo_count), 0);
    chk("reset_ready", 32'(sample_ready), 1);
    chk("reset_underrun", 32'(underrun), 0);

    for (int i = 0; i < 4; i++) begin
      sample_data = tbl[i].duty; sample_valid = 1'b1;
      tick();
    end
    chk("full_count", 32'(fifo_count), 4);
    chk("full_ready", 32'(sample_ready), 0);

    // Fifth sample held valid across the first frame.
    sample_data = tbl[4].duty;
    en = 1'b1; edge_idx = 0;
    for (int i = 0; i < 15; i++) tick_rec();
    chk("held_count", 32'(fifo_count), 4);
    chk("held_ready", 32'(sample_ready), 0);
    tick_rec();
    chk("pop_count", 32'(fifo_count), 3);
    chk("pop_ready", 32'(sample_ready), 1);
    chk("idle_frame", 32'(pat), 0);
    tick_rec();
    chk("fifth_accepted", 32'(fifo_count), 4);
    sample_valid = 1'b0;

    for (int j = 1; j <= 5; j++) begin
      while (edge_idx < 16 * (j + 1)) tick_rec();
      chk($sformatf("frame%0d_pattern", j), 32'(pat), 32'(mask(int'(tbl[j-1].duty))));
      chk($sformatf("frame%0d_underrun", j), 32'(underrun), 32'(tbl[j-1].exp_underrun));
    end

    while (edge_idx < 111) tick_rec();
    underrun_clr = 1'b1;
    tick_rec();
    underrun_clr = 1'b0;
    chk("repeat_duty_pattern", 32'(pat), 32'(mask(8)));
    chk("set_beats_clr", 32'(underrun), 1);
    underrun_clr = 1'b1;
    tick_rec();
    underrun_clr = 1'b0;
    chk("clr_alone", 32'(underrun), 0);

    tick_rec(); tick_rec();
    chk("midframe_high", 32'(pwm_out), 1);
    en = 1'b0;
    tick();
    chk("en_drop_pwm", 32'(pwm_out), 0);
    sample_data = 4'd3; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    chk("idle_push", 32'(fifo_count), 1);
    saw_high = 1'b0;
    for (int i = 0; i < 18; i++) begin
      tick();
      saw_high = saw_high | pwm_out;
    end
    chk("idle_quiet", 32'(saw_high), 0);
    chk("idle_no_underrun", 32'(underrun), 0);

    en = 1'b1; edge_idx = 0;
    for (int i = 0; i < 16; i++) tick_rec();
    chk("reenable_pattern", 32'(pat), 32'(mask(8)));
    chk("reenable_pop", 32'(fifo_count), 0);
    for (int i = 0; i < 16; i++) tick_rec();
    chk("after_idle_pattern", 32'(pat), 32'(mask(3)));
    chk("after_idle_underrun", 32'(underrun), 1);

    sample_valid = 1'b1; sample_data = 4'd9;
    tick_rec();
    sample_data = 4'd4;
    tick_rec();
    sample_valid = 1'b0;
    chk("two_queued", 32'(fifo_count), 2);
    tick_rec();
    chk("pre_reset_high", 32'(pwm_out), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_pwm", 32'(pwm_out), 0);
    chk("async_reset_count", 32'(fifo_count), 0);
    chk("async_reset_ready", 32'(sample_ready), 1);
    chk("async_reset_underrun", 32'(underrun), 0);
    en = 1'b0;
    tick();
    rst_n = 1'b1;
    en = 1'b1; edge_idx = 0;
    for (int i = 0; i < 16; i++) tick_rec();
    chk("post_reset_pattern", 32'(pat), 0);
    chk("post_reset_discarded", 32'(underrun), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
